riscv_dift_policy_ctrl: RTL

- Configuration and exception sequencer for the DIFT tag datapath in the EX stage.
- Holds the software-programmable Tag Propagation Register (TPR) and Tag Check Register (TCR), accessed through a CSR-style port.
- Decodes the per-class propagation mode and check enables for the instruction currently in ID.
- Latches tag-check exceptions from EX and sequences a trap request/acknowledge handshake towards the controller, stalling the pipe until software clears the event.

---
 rtl/riscv_dift_policy_ctrl_pkg.sv | 34 +++
 rtl/riscv_dift_policy_ctrl_if.sv | 21 ++
 rtl/riscv_dift_policy_decode.sv | 35 +++
 rtl/riscv_dift_policy_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/riscv_dift_policy_ctrl_pkg.sv
// Shared definitions for the DIFT policy controller: CSR map, FSM states,
// TCR field layout and the ALU propagation-mode width.
package riscv_defines;

  localparam int unsigned ALU_MODE_WIDTH = 2;

  localparam logic [1:0] DIFT_CSR_TPR      = 2'd0;
  localparam logic [1:0] DIFT_CSR_TCR      = 2'd1;
  localparam logic [1:0] DIFT_CSR_EXC_INFO = 2'd2;
  localparam logic [1:0] DIFT_CSR_EXC_CNT  = 2'd3;

  // Per-class TCR field: {d, s2, s1}
  localparam int unsigned TCR_FIELD_W = 3;
  localparam int unsigned TCR_S1_OFF  = 0;
  localparam int unsigned TCR_S2_OFF  = 1;
  localparam int unsigned TCR_D_OFF   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    LOCKED  = 2'd2
  } dift_exc_state_e;

  // Low-bit mask of the given width, saturating at 32 bits.
  function automatic logic [31:0] low_mask(input int unsigned width);
    logic [31:0] m;
    m = '0;
    for (int unsigned b = 0; b < 32; b++) begin
      if (b < width) m[b] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/riscv_dift_policy_ctrl_if.sv
// CSR access port and trap handshake between the controller and the DIFT block.
interface riscv_dift_policy_ctrl_if;

  logic        csr_we_i;
  logic [1:0]  csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        trap_req_o;
  logic        trap_ack_i;

  modport master (
    output csr_we_i, csr_addr_i, csr_wdata_i, trap_ack_i,
    input  csr_rdata_o, trap_req_o
  );

  modport slave (
    input  csr_we_i, csr_addr_i, csr_wdata_i, trap_ack_i,
    output csr_rdata_o, trap_req_o
  );

endinterface

// File: rtl/riscv_dift_policy_decode.sv
// Combinational lookup of propagation mode and check enables for one
// instruction class from the TPR/TCR contents. Reusable in ID.
module riscv_dift_policy_decode
  import riscv_defines::*;
#(
  parameter int unsigned NUM_CLASS = 8,
  parameter int unsigned MODE_W    = ALU_MODE_WIDTH,
  parameter int unsigned CLS_W     = $clog2(NUM_CLASS)
) (
  input  logic [31:0]       tpr_i,
  input  logic [31:0]       tcr_i,
  input  logic [CLS_W-1:0]  class_i,
  output logic [MODE_W-1:0] mode_o,
  output logic              check_s1_o,
  output logic              check_s2_o,
  output logic              check_d_o
);

  // Select the field of the matching class; unmatched indices decode to 0.
  always_comb begin
    mode_o     = '0;
    check_s1_o = 1'b0;
    check_s2_o = 1'b0;
    check_d_o  = 1'b0;
    for (int unsigned k = 0; k < NUM_CLASS; k++) begin
      if (class_i == CLS_W'(k)) begin
        mode_o     = tpr_i[MODE_W*k +: MODE_W];
        check_s1_o = tcr_i[TCR_FIELD_W*k + TCR_S1_OFF];
        check_s2_o = tcr_i[TCR_FIELD_W*k + TCR_S2_OFF];
        check_d_o  = tcr_i[TCR_FIELD_W*k + TCR_D_OFF];
      end
    end
  end

endmodule

// File: rtl/riscv_dift_policy_ctrl.sv
// DIFT policy controller: TPR/TCR configuration registers, per-class decode
// for the ID-stage instruction, and tag-check exception sequencing with a
// trap request/acknowledge handshake and a saturating event counter.
module riscv_dift_policy_ctrl
  import riscv_defines::*;
#(
  parameter int unsigned NUM_CLASS = 8,
  parameter int unsigned MODE_W    = ALU_MODE_WIDTH,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  riscv_dift_policy_ctrl_if.slave      bus,
  input  logic [$clog2(NUM_CLASS)-1:0] class_i,
  output logic [MODE_W-1:0]            mode_o,
  output logic                         check_s1_o,
  output logic                         check_s2_o,
  output logic                         check_d_o,
  input  logic                         ex_valid_i,
  input  logic                         exc_tag_i,
  input  logic [31:0]                  ex_pc_i,
  output logic                         halt_o,
  output logic [31:0]                  exc_pc_o
);

  localparam logic [31:0] TPR_MASK = low_mask(MODE_W * NUM_CLASS);
  localparam logic [31:0] TCR_MASK = low_mask(TCR_FIELD_W * NUM_CLASS);

  logic [31:0]      tpr_q, tcr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;
  logic             latch_pc;
  dift_exc_state_e  state_q, state_d;

  logic exc_event;
  logic info_clr;
  logic cnt_clr;

  assign exc_event = ex_valid_i & exc_tag_i;
  assign info_clr  = bus.csr_we_i & (bus.csr_addr_i == DIFT_CSR_EXC_INFO) & bus.csr_wdata_i[0];
  assign cnt_clr   = bus.csr_we_i & (bus.csr_addr_i == DIFT_CSR_EXC_CNT);

  // Configuration registers; bits outside the populated fields never stick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tpr_q <= '0;
      tcr_q <= '0;
    end else if (bus.csr_we_i) begin
      if (bus.csr_addr_i == DIFT_CSR_TPR) tpr_q <= bus.csr_wdata_i & TPR_MASK;
      if (bus.csr_addr_i == DIFT_CSR_TCR) tcr_q <= bus.csr_wdata_i & TCR_MASK;
    end
  end

  riscv_dift_policy_decode #(
    .NUM_CLASS (NUM_CLASS),
    .MODE_W    (MODE_W)
  ) u_decode (
    .tpr_i      (tpr_q),
    .tcr_i      (tcr_q),
    .class_i    (class_i),
    .mode_o     (mode_o),
    .check_s1_o (check_s1_o),
    .check_s2_o (check_s2_o),
    .check_d_o  (check_d_o)
  );

  // Exception FSM next state. A clear in LOCKED takes priority over a
  // coincident event: the event is counted but never starts a new trap.
  always_comb begin
    state_d  = state_q;
    latch_pc = 1'b0;
    ovf_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (exc_event) begin
          state_d  = PENDING;
          latch_pc = 1'b1;
        end
      end
      PENDING: begin
        if (exc_event) ovf_set = 1'b1;
        if (bus.trap_ack_i) state_d = LOCKED;
      end
      LOCKED: begin
        if (info_clr) state_d = IDLE;
        else if (exc_event) ovf_set = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter and overflow next values; a clear write beats a coincident event.
  always_comb begin
    cnt_d = cnt_q;
    if (exc_event && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    if (cnt_clr) cnt_d = '0;
    ovf_d = ovf_q | ovf_set;
    if (info_clr) ovf_d = 1'b0;
  end

  // Exception state, counter, overflow flag and faulting PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      exc_pc_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (latch_pc) exc_pc_o <= ex_pc_i;
    end
  end

  assign bus.trap_req_o = (state_q == PENDING);
  assign halt_o         = (state_q != IDLE);

  // CSR read mux.
  always_comb begin
    bus.csr_rdata_o = '0;
    case (bus.csr_addr_i)
      DIFT_CSR_TPR:      bus.csr_rdata_o = tpr_q;
      DIFT_CSR_TCR:      bus.csr_rdata_o = tcr_q;
      DIFT_CSR_EXC_INFO: bus.csr_rdata_o = {29'd0, ovf_q, (state_q == LOCKED), (state_q == PENDING)};
      DIFT_CSR_EXC_CNT:  bus.csr_rdata_o = 32'(cnt_q);
      default:           bus.csr_rdata_o = '0;
    endcase
  end

endmodule
